// File: rtl/lpc_i2s_out.sv
// lpc_i2s_out: FLAC stereo decorrelation, small L/R FIFO and I2S serialiser behind the lpc decoder.
// Optional: define LPC_I2S_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module lpc_i2s_out #(
  parameter int FIFO_AW   = 3,
  parameter int BCLK_HALF = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_rd_valid,
  output logic        phy_rd,
  input  logic [1:0]  phy_rd_chansgn,
  input  logic [16:0] phy_rd_data_chan0,
  input  logic [16:0] phy_rd_data_chan1,
  input  logic        out_en,
  input  logic        underrun_clr,
  output logic        underrun,
`ifdef LPC_I2S_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);
  // state | meaning
  // IDLE  | output disabled, or enabled this cycle and about to load the first frame
  // RUN   | serialising frames
  typedef enum logic {IDLE, RUN} state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = $clog2(BCLK_HALF);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wptr, rptr;
  logic [FIFO_AW:0]    count;
  logic                s1_valid;
  logic [1:0]          s1_chansgn;
  logic [16:0]         s1_c0, s1_c1;
  logic [DW-1:0]       div;
  logic [5:0]          b;
  logic [31:0]         frame;

  logic signed [17:0]  c0, c1, h;
  logic [15:0]         l_val, r_val;
  logic [FIFO_AW+1:0]  occ;
  logic                fetch, fall, load, push, pop, set_ur, sd_next;
  logic [5:0]          b_next;
  logic [4:0]          idx;

  always_comb begin
    c0    = signed'({s1_c0[16], s1_c0});
    c1    = signed'({s1_c1[16], s1_c1});
    h     = c1 >>> 1;
    l_val = 16'(c0);
    r_val = 16'(c1);
    case (s1_chansgn)
      2'd1: r_val = 16'(c0 - c1);
      2'd2: l_val = 16'(c0 + c1);
      2'd3: begin
        l_val = 16'(c0 + h + 18'(s1_c1[0]));
        r_val = 16'(c0 - h);
      end
      default: ;
    endcase
  end

  always_comb begin
    occ    = {1'b0, count} + (FIFO_AW+2)'(s1_valid) + (FIFO_AW+2)'(phy_rd);
    fetch  = phy_rd_valid && !phy_rd && (occ < (FIFO_AW+2)'(DEPTH));
    b_next = b + 6'd1;
    fall   = (state == RUN) && (div == DIV_LAST) && i2s_bclk;
    load   = out_en && ((state == IDLE) || (fall && b_next == 6'd0));
    push   = s1_valid;
    pop    = load && (count != '0);
    set_ur = load && (count == '0);
    // one-bit I2S delay: slot b carries bit (16-b) of L or (48-b) of R
    idx     = 5'd0;
    sd_next = 1'b0;
    if (b_next >= 6'd1 && b_next <= 6'd16) begin
      idx     = 5'd0 - b_next[4:0];
      sd_next = frame[idx];
    end else if (b_next >= 6'd33 && b_next <= 6'd48) begin
      idx     = 5'd16 - b_next[4:0];
      sd_next = frame[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (phy_rd && phy_rd_valid) begin
      s1_chansgn <= phy_rd_chansgn;
      s1_c0      <= phy_rd_data_chan0;
      s1_c1      <= phy_rd_data_chan1;
    end
    if (!rst && push) mem[wptr] <= {l_val, r_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phy_rd    <= 1'b0;
      s1_valid  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      div       <= '0;
      b         <= '0;
      frame     <= '0;
      underrun  <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      phy_rd   <= fetch;
      s1_valid <= phy_rd && phy_rd_valid;
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: ;
      endcase
      if (load) frame <= pop ? mem[rptr] : 32'd0;
      if (set_ur) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;

      if (!out_en) begin
        state     <= IDLE;
        div       <= '0;
        b         <= '0;
        i2s_bclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sdata <= 1'b0;
      end else if (state == IDLE) begin
        state <= RUN;
      end else if (div == DIV_LAST) begin
        div      <= '0;
        i2s_bclk <= ~i2s_bclk;
        if (i2s_bclk) begin
          b         <= b_next;
          i2s_lrclk <= b_next[5];
          i2s_sdata <= sd_next;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

`ifdef LPC_I2S_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      underrun_cnt <= '0;
    else if (underrun_clr)
      underrun_cnt <= set_ur ? 16'd1 : 16'd0;
    else if (set_ur && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lpc_i2s_out.sv
// Bench for lpc_i2s_out: a queued lpc source, an integer decorrelation model and an I2S frame monitor.
module tb_lpc_i2s_out;
  logic        clk, rst, phy_rd_valid, phy_rd, out_en, underrun_clr, underrun;
  logic [1:0]  phy_rd_chansgn;
  logic [16:0] phy_rd_data_chan0, phy_rd_data_chan1;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
`ifdef LPC_I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  lpc_i2s_out #(.FIFO_AW(3), .BCLK_HALF(2)) dut (
    .clk(clk), .rst(rst),
    .phy_rd_valid(phy_rd_valid), .phy_rd(phy_rd),
    .phy_rd_chansgn(phy_rd_chansgn),
    .phy_rd_data_chan0(phy_rd_data_chan0), .phy_rd_data_chan1(phy_rd_data_chan1),
    .out_en(out_en), .underrun_clr(underrun_clr), .underrun(underrun),
`ifdef LPC_I2S_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cs;
    logic [16:0] c0;
    logic [16:0] c1;
  } item_t;

  item_t       src_q[$];
  logic [31:0] exp_q[$];
  int checks = 0, failures = 0;
  int strobes = 0, b2b = 0;
  bit prev_rd = 0;
  int slot = 0, cur_bi = 0;
  bit prev_bclk = 0, have_frame = 0, cur_has_data = 0, lr_bad = 0;
  logic [31:0] cur_exp;
  logic [63:0] fb;
  int data_frames = 0, zero_frames = 0, frames_started = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // FLAC reconstruction done with plain integers; mid-side uses the mid*2|side&1 form
  function automatic logic [31:0] model(input item_t it);
    int a, s, l, r, mid;
    a = $signed(it.c0);
    s = $signed(it.c1);
    case (it.cs)
      2'd0: begin l = a; r = s; end
      2'd1: begin l = a; r = a - s; end
      2'd2: begin l = a + s; r = s; end
      default: begin
        mid = a * 2 + (s & 1);
        l = (mid + s) >>> 1;
        r = (mid - s) >>> 1;
      end
    endcase
    return {l[15:0], r[15:0]};
  endfunction

  function automatic logic [63:0] frame_bits_of(input logic [31:0] p);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[1 + k]  = p[31 - k];
      v[33 + k] = p[15 - k];
    end
    return v;
  endfunction

  task automatic drive_src();
    if (src_q.size() != 0) begin
      phy_rd_valid      = 1'b1;
      phy_rd_chansgn    = src_q[0].cs;
      phy_rd_data_chan0 = src_q[0].c0;
      phy_rd_data_chan1 = src_q[0].c1;
    end else begin
      phy_rd_valid      = 1'b0;
      phy_rd_chansgn    = 2'd0;
      phy_rd_data_chan0 = '0;
      phy_rd_data_chan1 = '0;
    end
  endtask

  task automatic add_item(input int cs, input int c0, input int c1);
    item_t it;
    it.cs = cs[1:0];
    it.c0 = c0[16:0];
    it.c1 = c1[16:0];
    src_q.push_back(it);
  endtask

  task automatic tick();
    bit cap;
    @(negedge clk);
    cap = (phy_rd === 1'b1) && phy_rd_valid && !rst;
    if (phy_rd === 1'b1) begin
      strobes++;
      if (prev_rd) b2b++;
    end
    prev_rd = (phy_rd === 1'b1);
    if (cap) exp_q.push_back(model(src_q[0]));
    if (rst || !out_en) begin
      slot = 0; cur_bi = 0; prev_bclk = 0; have_frame = 0;
    end else begin
      if (i2s_bclk === 1'b1 && !prev_bclk) begin
        cur_bi = slot % 64;
        if (cur_bi == 0) begin
          have_frame = 1; lr_bad = 0; fb = '0;
          frames_started++;
          cur_has_data = (exp_q.size() != 0);
          cur_exp = cur_has_data ? exp_q.pop_front() : 32'd0;
        end
        fb[cur_bi] = i2s_sdata;
        if (i2s_lrclk !== (cur_bi >= 32)) lr_bad = 1;
        if (cur_bi == 63 && have_frame) begin
          check("frame_sdata", fb, frame_bits_of(cur_exp));
          check("frame_lrclk", 64'(lr_bad), 64'd0);
          if (cur_has_data) data_frames++; else zero_frames++;
        end
        slot++;
      end
      prev_bclk = (i2s_bclk === 1'b1);
    end
    if (rst) exp_q.delete();
    @(posedge clk);
    #1;
    if (cap) void'(src_q.pop_front());
    drive_src();
  endtask

  initial begin
    int z0, fs0;
    rst = 1'b1; out_en = 1'b0; underrun_clr = 1'b0;
    drive_src();
    repeat (3) tick();
    check("reset_outputs", 64'({phy_rd, underrun, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
`ifdef LPC_I2S_UNDERRUN_CNT_EN
    check("reset_cnt", 64'(underrun_cnt), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // prefill with output disabled: directed decorrelation vectors then random pairs
    add_item(0, 'h1234, -5);
    add_item(1, 1000, -24);
    add_item(2, 5, -3);
    add_item(3, 100, 7);
    add_item(3, 0, -7);
    for (int i = 0; i < 15; i++) add_item($urandom_range(0, 3), int'($urandom()), int'($urandom()));
    drive_src();
    strobes = 0; b2b = 0;
    repeat (60) tick();
    check("prefill_strobes", 64'(strobes), 64'd8);
    check("prefill_no_b2b", 64'(b2b), 64'd0);
    check("prefill_rd_idle", 64'(phy_rd), 64'd0);
    check("prefill_no_underrun", 64'(underrun), 64'd0);

    // one refill strobe per frame pop
    strobes = 0;
    out_en = 1'b1;
    repeat (1024) tick();
    check("refill_strobes", 64'(strobes), 64'd4);
    check("flow_no_underrun", 64'(underrun), 64'd0);

    for (int i = 0; i < 6000 && data_frames < 20; i++) tick();
    check("data_frames", 64'(data_frames), 64'd20);

    z0 = zero_frames;
    for (int i = 0; i < 600 && zero_frames == z0; i++) tick();
    check("first_zero_frame", 64'(zero_frames), 64'(z0 + 1));
    check("underrun_set", 64'(underrun), 64'd1);

    for (int i = 0; i < 300 && cur_bi != 1; i++) tick();
    check("wait_b1", 64'(cur_bi), 64'd1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_cleared", 64'(underrun), 64'd0);
`ifdef LPC_I2S_UNDERRUN_CNT_EN
    check("cnt_cleared", 64'(underrun_cnt), 64'd0);
`endif
    fs0 = frames_started;
    for (int i = 0; i < 1000 && frames_started < fs0 + 3; i++) tick();
    check("three_frames", 64'(frames_started), 64'(fs0 + 3));
    check("underrun_reset_after_clr", 64'(underrun), 64'd1);
`ifdef LPC_I2S_UNDERRUN_CNT_EN
    check("cnt_three", 64'(underrun_cnt), 64'd3);
`endif

    // reset in the middle of a frame with pairs queued
    out_en = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) add_item($urandom_range(0, 3), int'($urandom()), int'($urandom()));
    drive_src();
    repeat (40) tick();
    out_en = 1'b1;
    for (int i = 0; i < 600 && cur_bi != 20; i++) tick();
    check("wait_b20", 64'(cur_bi), 64'd20);
    rst = 1'b1;
    tick();
    check("midrun_reset_outputs", 64'({phy_rd, underrun, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
    rst = 1'b0;
    z0 = zero_frames;
    for (int i = 0; i < 400 && zero_frames == z0; i++) tick();
    check("post_reset_zero_frame", 64'(zero_frames), 64'(z0 + 1));
    check("post_reset_underrun", 64'(underrun), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lpc_i2s_out.md
Name: lpc_i2s_out

Overview:
- Downstream stage of the `lpc` FLAC decoder.
- Pulls decoded sample pairs from the lpc phy read port and undoes the FLAC stereo decorrelation (independent, left-side, side-right, mid-side).
- Buffers the resulting 16-bit L/R pairs in a small FIFO and serialises them as a standard I2S stream (BCLK, LRCLK, SDATA) for the audio DAC.

Parameters:
- FIFO_AW, 3, log2 of FIFO depth in L/R pairs (depth 8).
- BCLK_HALF, 32, clk cycles per BCLK half-period. Must be >= 2. BCLK = clk/(2*BCLK_HALF).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- phy_rd_valid  input  1  lpc has a sample pair available
- phy_rd  output  1  one-cycle read strobe to lpc
- phy_rd_chansgn  input  2  channel assignment: 0 indep, 1 left-side, 2 side-right, 3 mid-side
- phy_rd_data_chan0  input  17  subframe 0 sample, signed
- phy_rd_data_chan1  input  17  subframe 1 sample, signed
- out_en  input  1  enable I2S output
- underrun_clr  input  1  clears underrun flag
- underrun  output  1  sticky: a frame was sent with an empty FIFO
- i2s_bclk  output  1  bit clock
- i2s_lrclk  output  1  word select: 0 left, 1 right
- i2s_sdata  output  1  serial data

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: phy_rd=0, underrun=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0. FIFO empty, stage register invalid, bit index 0, divider 0.
- **Fetch handshake**
  - phy_rd is a register. It is set to 1 for one cycle when phy_rd_valid=1 && phy_rd=0 && (fifo_count + s1_valid + phy_rd) < 2^FIFO_AW.
  - At most one strobe every 2 cycles.
  - Data is captured at the edge where phy_rd=1 && phy_rd_valid=1. chansgn, chan0 and chan1 go to stage reg s1, and s1_valid is set.
  - If phy_rd=1 but phy_rd_valid=0, nothing is captured.
- **Decorrelate** (s1 → FIFO write on the next edge; 1-cycle latency; all arithmetic 17/18-bit signed; results truncated to low 16 bits, wrap, no saturation). With c0=chan0, c1=chan1, h = c1>>>1 (arithmetic):
  - 0: L=c0, R=c1
  - 1: L=c0, R=c0-c1
  - 2: L=c0+c1, R=c1
  - 3: L=c0+h+c1[0], R=c0-h
- The free-space rule guarantees no write to a full FIFO. The FIFO is a 32-bit wide register array with wrap-around read/write pointers and a count.
- **I2S** (out_en=1)
  - The divider counts 0..BCLK_HALF-1, then i2s_bclk toggles.
  - On each BCLK falling edge (1→0), bit index b advances 0..63 (wraps), and lrclk/sdata update on the same clk edge.
  - i2s_lrclk = (b>=32).
  - i2s_sdata = L[16-b] for b in 1..16; R[48-b] for b in 33..48; 0 otherwise. This is the standard I2S one-bit delay, MSB first, 32-bit slots.
  - On the falling edge that enters b=0, the frame register loads the FIFO head and pops it.
  - If the FIFO is empty at that edge, the frame is zeros, there is no pop, and underrun is set.
  - A FIFO write and pop in the same cycle are both honoured; count is unchanged.
- out_en=0:
  - Divider, b and BCLK are held at 0; lrclk=0, sdata=0.
  - The FIFO keeps filling until full.
  - On out_en rising, the first frame starts at b=0 with a pop.
  - Dropping out_en mid-frame abandons the frame; the popped pair is lost.
- underrun_clr=1 clears underrun. If a set and a clear occur in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values, FIFO contents are discarded, and any in-flight phy_rd capture is dropped. lpc is re-synchronised by its own reset.

Optional Feature:
- Macro `LPC_I2S_UNDERRUN_CNT_EN`.
- Defined: adds output port underrun_cnt (16 bits). It increments, saturating at 16'hFFFF, on every zero-filled frame, and is cleared by rst or underrun_clr. If an increment and underrun_clr occur in the same cycle, the result is 1.
- Undefined: the port and counter are absent; only the sticky underrun flag exists.

Test Plan:
- chansgn=0, c0=16'h1234, c1=-5 → FIFO pair L=16'h1234, R=16'hFFFB; on I2S with BCLK_HALF=2, sdata bits b1..16 = 0x1234 and b33..48 = 0xFFFB.
- chansgn=1, c0=1000, c1=-24 → L=1000, R=1024. chansgn=2, c0=5, c1=-3 → L=2, R=-3.
- chansgn=3, c0=100, c1=7 → L=104, R=97. chansgn=3, c0=0, c1=-7 → L=-3, R=4.
- out_en=0, phy_rd_valid held 1 → exactly 8 phy_rd strobes then phy_rd stays 0. Raise out_en → after each frame pop, one new strobe; 8 pairs emitted in order.
- out_en=1, phy_rd_valid=0 → underrun=1 after the first b=0 edge and sdata all zero. Pulse underrun_clr → underrun=0. With the macro, underrun_cnt counts frames (3 frames → 3).
- Assert rst at b=20 with 5 pairs queued → next cycle all outputs 0; after release with out_en=1, the first frame is an underrun (FIFO empty).
